pwm_reg_cmd_master: RTL and testbench
=====================================

Name: pwm_reg_cmd_master

Overview:
- Command-driven initiator for the PWM register interface (wr_en/rd_en/addr/wr_data/rd_data).
- Receives byte commands on a valid/ready stream, typically from the UART RX path. Issues single-cycle register writes and reads to the PWM register block.
- Returns an acknowledge byte, a read-data byte sequence or an error byte on a valid/ready output stream, typically to the UART TX path.
- Sits between the host serial link and the PWM register block. It is the only driver of that block's access port.

Parameters:
- WIDTH, 16, register data width; must be a multiple of 8. NB = WIDTH/8 data bytes per access.
- ADDR_W, 4, register address width. Taken from the low ADDR_W bits of the address byte.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  command byte valid
- in_data  in  8  command byte
- in_ready  out  1  command byte accepted when in_valid && in_ready
- out_valid  out  1  response byte valid
- out_data  out  8  response byte
- out_ready  in  1  response byte consumed when out_valid && out_ready
- wr_en  out  1  register write strobe, one cycle
- rd_en  out  1  register read strobe, one cycle
- addr  out  ADDR_W  register address
- wr_data  out  WIDTH  register write data
- rd_data  in  WIDTH  register read data, combinational from the slave in the rd_en cycle
- busy  out  1  high whenever state != IDLE

Behaviour:
- One clock domain. Reset is synchronous and active-high: clock port clk, reset port rst.
- Reset values: in_ready=0, out_valid=0, out_data=0, wr_en=0, rd_en=0, addr=0, wr_data=0, busy=0, state=IDLE, all byte counters 0.
- Reset asserted mid-command or mid-response aborts immediately. No strobe is issued after reset, and the partial command is discarded.
- Command format:
  - Write: 0x57, addr byte, NB data bytes MSB first.
  - Read: 0x52, addr byte.
- FSM states: IDLE, GET_ADDR, GET_DATA, DO_WR, DO_RD, SEND.
- IDLE: in_ready=1.
  - 0x57 -> GET_ADDR with op=write.
  - 0x52 -> GET_ADDR with op=read.
  - Any other byte -> SEND with the single response byte 0x45 ('E'). The bad byte is consumed.
- GET_ADDR: in_ready=1. On accept, latch addr <= in_data[ADDR_W-1:0]. Write -> GET_DATA with count 0. Read -> DO_RD.
- GET_DATA: in_ready=1. On accept, shift wr_data <= {wr_data[WIDTH-9:0], in_data}. After the NB-th byte -> DO_WR.
- DO_WR: in_ready=0. wr_en=1 for exactly this cycle with addr/wr_data stable. Next -> SEND with the single byte 0x4B ('K').
- DO_RD: in_ready=0. rd_en=1 for exactly this cycle. rd_data is captured into the response shift register at this edge. Next -> SEND with NB bytes, MSB first.
- SEND: in_ready=0, out_valid=1, out_data = current byte.
  - The byte advances only on out_ready. It is held stable under back-pressure.
  - After the last byte is accepted -> IDLE. in_ready is high in the following cycle.
- Latency, measured from the accepting edge N of the last command byte:
  - Strobe is high in cycle N+1.
  - out_valid is first high in cycle N+2.
- Throughput: one command at a time. No command bytes are accepted while in DO_* or SEND.
- Invariants:
  - wr_en and rd_en are never high together.
  - Neither strobe is high longer than 1 cycle.
  - addr and wr_data change only in GET_ADDR/GET_DATA.
- in_valid held low mid-command: the FSM waits indefinitely with no timeout.
- Address bits above ADDR_W in the address byte are ignored.

Decomposition:
- Package pwm_reg_pkg:
  - Opcode constants: OP_WR=8'h57, OP_RD=8'h52.
  - Response constants: RSP_ACK=8'h4B, RSP_ERR=8'h45.
  - State enum.
  - Register address constants, shared with the PWM register block.
- No sub-module. The byte shift registers are inline.

Test Plan:
- Write: stream 57 04 12 34 -> wr_en one cycle with addr=4, wr_data=16'h1234, one cycle after the 0x34 accept; then out 4B; busy low afterwards.
- Read: slave model returns 16'hBEEF at addr 8; stream 52 08 -> rd_en one cycle with addr=8; out bytes BE then EF; no wr_en.
- Bad opcode: stream 33 then 52 0E -> out 45; 0x33 generates no strobe; the following read completes normally.
- Back-pressure: read returning 16'hA5C3 with out_ready low for 5 cycles per byte -> out_data stable while stalled; exactly 2 bytes A5, C3; in_ready=0 throughout SEND.
- Gaps and truncation:
  - Write with in_valid gaps of 3 cycles between bytes -> same result as back-to-back.
  - rst pulsed after the 57 08 12 bytes -> no wr_en; a subsequent 52 08 returns the slave value unchanged.
- Protocol assertions across a random command mix: wr_en and rd_en never both high; each strobe lasts 1 cycle; out_valid never drops before out_ready.

Source files
------------

// File: rtl/pwm_reg_pkg.sv
// Shared definitions for the PWM register interface: command opcodes,
// response bytes, command-master states and register addresses.
package pwm_reg_pkg;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        DO_WR,
        DO_RD,
        SEND
    } state_e;

    // Register map of the PWM register block.
    localparam int         REG_ADDR_W = 4;
    localparam logic [3:0] REG_CTRL   = 4'h0;
    localparam logic [3:0] REG_PERIOD = 4'h4;
    localparam logic [3:0] REG_DUTY   = 4'h8;
    localparam logic [3:0] REG_STATUS = 4'hC;

endpackage

// File: rtl/pwm_reg_cmd_master.sv
// Byte-command initiator for the PWM register block: parses write/read
// commands from a byte stream, strobes the register port, returns a response.
module pwm_reg_cmd_master
    import pwm_reg_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [7:0]        out_data,
    input  logic              out_ready,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [WIDTH-1:0]  wr_data,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              busy
);

    localparam int NB    = WIDTH / 8;
    localparam int CNT_W = $clog2(NB + 1);

    state_e             state_q, state_d;
    logic               is_wr_q, is_wr_d;
    logic               in_ready_q, in_ready_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [WIDTH-1:0]   wr_data_q, wr_data_d;
    logic [WIDTH-1:0]   rsp_q, rsp_d;
    logic               accept;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        state_d   = state_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        rsp_d     = rsp_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'h00;
        accept    = in_valid && in_ready_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_data == OP_WR) begin
                        is_wr_d = 1'b1;
                        state_d = GET_ADDR;
                    end else if (in_data == OP_RD) begin
                        is_wr_d = 1'b0;
                        state_d = GET_ADDR;
                    end else begin
                        rsp_d   = WIDTH'(RSP_ERR) << (WIDTH - 8);
                        cnt_d   = CNT_W'(1);
                        state_d = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (accept) begin
                    addr_d  = in_data[ADDR_W-1:0];
                    cnt_d   = '0;
                    state_d = is_wr_q ? GET_DATA : DO_RD;
                end
            end
            GET_DATA: begin
                if (accept) begin
                    wr_data_d = (wr_data_q << 8) | WIDTH'(in_data);
                    if (cnt_q == CNT_W'(NB - 1)) begin
                        state_d = DO_WR;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DO_WR: begin
                wr_en   = 1'b1;
                rsp_d   = WIDTH'(RSP_ACK) << (WIDTH - 8);
                cnt_d   = CNT_W'(1);
                state_d = SEND;
            end
            DO_RD: begin
                rd_en   = 1'b1;
                rsp_d   = rd_data;
                cnt_d   = CNT_W'(NB);
                state_d = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_data  = rsp_q[WIDTH-1 -: 8];
                if (out_ready) begin
                    rsp_d = rsp_q << 8;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered from the next state so in_ready is low through reset.
        in_ready_d = (state_d == IDLE) || (state_d == GET_ADDR) || (state_d == GET_DATA);
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            in_ready_q <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_data_q  <= '0;
            rsp_q      <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            in_ready_q <= in_ready_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wr_data_q  <= wr_data_d;
            rsp_q      <= rsp_d;
        end
    end

    assign in_ready = in_ready_q;
    assign addr     = addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_pwm_reg_cmd_master.sv
// Randomized self-checking bench for pwm_reg_cmd_master against a
// command-level reference model (expected strobes and response bytes).
module tb_pwm_reg_cmd_master;

    localparam int WIDTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              out_valid;
    logic [7:0]        out_data;
    logic              out_ready;
    logic              wr_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wr_data;
    logic [WIDTH-1:0]  rd_data;
    logic              busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pwm_reg_cmd_master #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    // Slave register file: combinational read, write on the strobe edge.
    logic [15:0] slave_mem [16] = '{3: 16'hA5C3, 8: 16'hBEEF, default: 16'h0000};
    assign rd_data = slave_mem[addr];
    always @(posedge clk) if (wr_en) slave_mem[addr] <= wr_data;

    // Response back-pressure: manual level or a random per-cycle bit.
    logic rnd_ready = 1'b0;
    logic man_ready = 1'b1;
    logic rnd_bit   = 1'b1;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);
    assign out_ready = rnd_ready ? rnd_bit : man_ready;

    // Reference model state and expectations.
    logic [15:0] ref_mem [16] = '{3: 16'hA5C3, 8: 16'hBEEF, default: 16'h0000};
    logic [19:0] exp_wr [$];
    logic [3:0]  exp_rd [$];
    logic [7:0]  exp_out[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Continuous protocol / scoreboard monitor, sampling on the falling edge.
    logic       prev_wr = 1'b0, prev_rd = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
    logic [7:0] prev_od = 8'h00;
    always @(negedge clk) begin
        if (!rst) begin
            if (wr_en) begin
                check("strobe_excl", rd_en, 0);
                check("wr_len", prev_wr, 0);
                if (exp_wr.size() == 0) check("wr_unexpected", 1, 0);
                else begin
                    check("wr_addr", addr, exp_wr[0][19:16]);
                    check("wr_data", wr_data, exp_wr[0][15:0]);
                    void'(exp_wr.pop_front());
                end
            end
            if (rd_en) begin
                check("rd_len", prev_rd, 0);
                if (exp_rd.size() == 0) check("rd_unexpected", 1, 0);
                else begin
                    check("rd_addr", addr, exp_rd[0]);
                    void'(exp_rd.pop_front());
                end
            end
            if (prev_ov && !prev_or) begin
                check("out_valid_hold", out_valid, 1);
                check("out_data_hold", out_data, prev_od);
            end
            if (out_valid) check("in_ready_send", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exp_out.size() == 0) check("out_unexpected", 1, 0);
                else begin
                    check("out_byte", out_data, exp_out[0]);
                    void'(exp_out.pop_front());
                end
            end
        end
        prev_wr <= wr_en;
        prev_rd <= rd_en;
        prev_ov <= out_valid;
        prev_or <= out_ready;
        prev_od <= out_data;
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        while (!in_ready && t < 500) begin
            t++;
            @(negedge clk);
        end
        if (t >= 500) check("in_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    // Reference model: derive expected strobes and response from the command bytes.
    task automatic model_cmd(input logic [31:0] bytes, input int n);
        logic [7:0] b [4];
        for (int i = 0; i < n; i++) b[i] = bytes[8*(n-1-i) +: 8];
        if (b[0] == 8'h57 && n == 4) begin
            exp_wr.push_back({b[1][3:0], b[2], b[3]});
            ref_mem[b[1][3:0]] = {b[2], b[3]};
            exp_out.push_back(8'h4B);
        end else if (b[0] == 8'h52 && n == 2) begin
            exp_rd.push_back(b[1][3:0]);
            exp_out.push_back(ref_mem[b[1][3:0]][15:8]);
            exp_out.push_back(ref_mem[b[1][3:0]][7:0]);
        end else begin
            exp_out.push_back(8'h45);
        end
    endtask

    task automatic run_cmd(input logic [31:0] bytes, input int n, input int gap);
        model_cmd(bytes, n);
        for (int i = 0; i < n; i++) begin
            send_byte(bytes[8*(n-1-i) +: 8]);
            if (i < n - 1) repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_done();
        int t = 0;
        while ((exp_out.size() != 0 || busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("done_in_time", (t < 2000), 1);
        check("busy_after", busy, 0);
    endtask

    initial begin
        logic [7:0] op;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_strobes", {wr_en, rd_en}, 0);
        check("rst_addr", addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Write: strobe one cycle after last accept, ack the cycle after.
        run_cmd(32'h57041234, 4, 0);
        check("wr_strobe_lat", wr_en, 1);
        check("wr_lat_addr", addr, 4'h4);
        check("wr_lat_data", wr_data, 16'h1234);
        @(posedge clk); #1;
        check("wr_strobe_drop", wr_en, 0);
        check("ack_lat_valid", out_valid, 1);
        check("ack_lat_data", out_data, 8'h4B);
        wait_done();

        // Read of preloaded 0xBEEF at address 8.
        run_cmd(32'h00005208, 2, 0);
        check("rd_strobe_lat", rd_en, 1);
        check("rd_no_wr", wr_en, 0);
        check("rd_lat_addr", addr, 4'h8);
        @(posedge clk); #1;
        check("rd_strobe_drop", rd_en, 0);
        check("rd_first_byte", out_data, 8'hBE);
        wait_done();

        // Bad opcode, then a normal read.
        run_cmd(32'h00000033, 1, 0);
        check("bad_no_strobe", {wr_en, rd_en}, 0);
        check("bad_err_valid", out_valid, 1);
        check("bad_err_byte", out_data, 8'h45);
        wait_done();
        run_cmd(32'h0000520E, 2, 0);
        wait_done();

        // Back-pressure: each response byte stalled for 5 cycles.
        man_ready = 1'b0;
        run_cmd(32'h00005203, 2, 0);
        for (int k = 0; k < 2; k++) begin
            int t = 0;
            while (!out_valid && t < 50) begin @(posedge clk); #1; t++; end
            check("bp_valid_seen", out_valid, 1);
            repeat (5) begin @(posedge clk); #1; end
            check("bp_in_ready_low", in_ready, 0);
            man_ready = 1'b1;
            @(posedge clk); #1;
            man_ready = 1'b0;
        end
        check("bp_all_bytes", exp_out.size(), 0);
        man_ready = 1'b1;
        wait_done();

        // Write with 3-cycle gaps between bytes.
        run_cmd(32'h57055678, 4, 3);
        check("gap_wr_strobe", wr_en, 1);
        check("gap_wr_addr", addr, 4'h5);
        check("gap_wr_data", wr_data, 16'h5678);
        wait_done();

        // Truncated write aborted by reset: no strobe, slave value unchanged.
        send_byte(8'h57);
        send_byte(8'h08);
        send_byte(8'h12);
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", busy, 0);
        check("abort_no_wr", wr_en, 0);
        rst = 1'b0;
        repeat (4) begin @(posedge clk); #1; check("abort_quiet", {wr_en, rd_en, out_valid}, 0); end
        run_cmd(32'h00005208, 2, 0);
        wait_done();

        // Random command mix under random back-pressure.
        rnd_ready = 1'b1;
        for (int c = 0; c < 60; c++) begin
            int sel;
            int gap;
            sel = $urandom_range(0, 9);
            gap = $urandom_range(0, 2);
            if (sel < 4) begin
                run_cmd({8'h57, 8'($urandom), 16'($urandom)}, 4, gap);
            end else if (sel < 8) begin
                run_cmd({16'h0000, 8'h52, 8'($urandom)}, 2, gap);
            end else begin
                op = 8'($urandom);
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
                run_cmd({24'h0, op}, 1, gap);
            end
            wait_done();
        end
        rnd_ready = 1'b0;

        repeat (3) @(posedge clk);
        check("final_wr_empty", exp_wr.size(), 0);
        check("final_rd_empty", exp_rd.size(), 0);
        check("final_out_empty", exp_out.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
